systolic_feed_ctrl: RTL and testbench
=====================================

// Module: systolic_feed_ctrl
// PURPOSE
//  Sequences one 4x4 block multiply on systolic_array_4x4 (Q8.8 fixed point).
//  - Accepts K column/row vector pairs (A column k, B row k) over a valid/ready handshake.
//  - Skews the lanes, clears the array before each job, and drains after the last pair.
//  - Captures the four result rows and holds them behind a result handshake.
//  - Sits between the block-level scheduler and the array; drives north_in*/west_in* and the array reset.
// PARAMETERS
//  BIT_WIDTH   16    operand width (signed Q8.8)
//  FRAC_WIDTH  8     fraction bits; passed through to the array, unused here
//  N           4     array dimension; only 4 is supported
//  MAX_K       255   largest k_len accepted
//  DRAIN_CYC   8     zero-feed cycles after the last pair; must be >= 2*N
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            synchronous reset, active low
//  start      in   1            job request; sampled in IDLE only
//  k_len      in   8            vector pairs in the job; sampled with start
//  busy       out  1            high whenever state != IDLE
//  in_valid   in   1            a_col/b_row are valid
//  in_ready   out  1            high in FEED only
//  a_col      in   4*BIT_WIDTH  A column k; lane i = [i*BW +: BW] -> west_in_i
//  b_row      in   4*BIT_WIDTH  B row k; lane j -> north_in_j
//  arr_rst_n  out  1            to array rst_n; = rst_n & ~(state==CLEAR)
//  west_in0..3  out BIT_WIDTH   skewed west operands
//  north_in0..3 out BIT_WIDTH   skewed north operands
//  row0..3    in   4*BIT_WIDTH  array accumulator rows
//  res_valid  out  1            captured rows are valid
//  res_ready  in   1            consumer accepts the result
//  res_row0..3 out 4*BIT_WIDTH  captured result rows
// BEHAVIOUR
//  Reset (rst_n=0 at edge), including mid-job:
//   state=IDLE; all skew registers and counters zeroed; west/north=0; res_*=0;
//   in_ready=0; arr_rst_n=0 while rst_n=0.
//  FSM states: IDLE -> CLEAR -> FEED -> DRAIN -> HOLD -> IDLE
//   IDLE : start=1 -> latch k_len, go to CLEAR. start is ignored in every other state.
//   CLEAR: one cycle with arr_rst_n=0 and zero feed.
//          Next state is FEED if k_len!=0, otherwise DRAIN.
//   FEED : in_ready=1. A pair is accepted when in_valid&in_ready.
//          - accept: lane inputs = a_col/b_row.
//          - no accept (bubble): lane inputs = 0; a zero pair adds nothing to the result.
//          - When accepted count reaches k_len, go to DRAIN on the same edge.
//   DRAIN: zero feed for DRAIN_CYC cycles. On the last cycle, capture row0..3 into res_row0..3.
//          Next state is HOLD.
//   HOLD : res_valid=1 and res_row* are held stable.
//          res_ready=1 -> go to IDLE with res_valid=0 on the same edge.
//  Skew: lane i of both west and north passes through i+1 registers.
//   - A pair accepted at edge t reaches PE(i,j) at t+1+i+j.
//   - Lanes are registered outputs; no combinational path from a_col/b_row.
//  Latency: start -> first in_ready is 2 cycles.
//   With no bubbles, res_valid rises 2 + k_len + DRAIN_CYC cycles after start.
//  Counters: k counter is 8 bits and saturates at k_len; k_len>MAX_K is clamped to MAX_K.
//   Drain counter is ceil(log2(DRAIN_CYC+1)) bits.
//  No arithmetic is performed on data; widths pass through unchanged.
// CONFIGURATION
//  BUBBLE_CNT_EN defined:
//   - adds output bubble_cnt [15:0]: FEED cycles with in_valid=0.
//   - cleared in CLEAR, saturates at 16'hFFFF, held through HOLD, reset to 0.
//  BUBBLE_CNT_EN undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  systolic_pkg: N, BIT_WIDTH defaults, state enum {IDLE,CLEAR,FEED,DRAIN,HOLD}.
//  Sub-module skew_line #(BIT_WIDTH, DEPTH): DEPTH-stage shift register with sync clear.
//   Instantiated 8 times (4 west, 4 north), DEPTH = lane index + 1.
// TESTING (bench instantiates systolic_feed_ctrl + systolic_array_4x4)
//  1 k_len=4, a_col[k] all lanes=(k+1)*16'h0100, b_row all 16'h0100, no bubbles
//    -> every res element 16'h0A00; res_valid exactly 14 cycles after start.
//  2 Same data, in_valid low every other FEED cycle
//    -> same 16'h0A00 results; bubble_cnt=3 (BUBBLE_CNT_EN).
//  3 Two back-to-back jobs, second with all-zero b_row
//    -> second result all zero (CLEAR verified); arr_rst_n low exactly 1 cycle per job.
//  4 k_len=0 -> no in_ready pulse; res_valid after 2+DRAIN_CYC cycles with all rows 0.
//  5 Hold res_ready low 5 cycles in HOLD and pulse start
//    -> res_row* stable, busy=1, start ignored; IDLE one cycle after res_ready.
//  6 rst_n low 1 cycle after 2 accepted pairs
//    -> outputs 0, IDLE next cycle; a fresh job then returns correct results.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults and the FSM state type for the systolic feed controller.
package systolic_pkg;

  localparam int DEF_N          = 4;
  localparam int DEF_BIT_WIDTH  = 16;
  localparam int DEF_FRAC_WIDTH = 8;
  localparam int DEF_MAX_K      = 255;
  localparam int DEF_DRAIN_CYC  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    HOLD
  } state_t;

endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage shift register with synchronous clear, used to skew one
// operand lane so that lane i arrives at the array edge i cycles after lane 0.
module skew_line
  import systolic_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [BIT_WIDTH-1:0] d,
  output logic [BIT_WIDTH-1:0] q
);

  logic [BIT_WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per cycle; clr empties the whole line at once.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences one 4x4 block multiply on systolic_array_4x4.
// Clears the array, feeds K skewed A-column/B-row pairs, drains, then holds the
// captured rows behind a result handshake.
// Optional feature macro: BUBBLE_CNT_EN adds output bubble_cnt (FEED cycles with
// in_valid low, saturating at 16'hFFFF).
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int N          = DEF_N,
  parameter int MAX_K      = DEF_MAX_K,
  parameter int DRAIN_CYC  = DEF_DRAIN_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             k_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*BIT_WIDTH-1:0] a_col,
  input  logic [4*BIT_WIDTH-1:0] b_row,
  output logic                   arr_rst_n,
  output logic [BIT_WIDTH-1:0]   west_in0,
  output logic [BIT_WIDTH-1:0]   west_in1,
  output logic [BIT_WIDTH-1:0]   west_in2,
  output logic [BIT_WIDTH-1:0]   west_in3,
  output logic [BIT_WIDTH-1:0]   north_in0,
  output logic [BIT_WIDTH-1:0]   north_in1,
  output logic [BIT_WIDTH-1:0]   north_in2,
  output logic [BIT_WIDTH-1:0]   north_in3,
  input  logic [4*BIT_WIDTH-1:0] row0,
  input  logic [4*BIT_WIDTH-1:0] row1,
  input  logic [4*BIT_WIDTH-1:0] row2,
  input  logic [4*BIT_WIDTH-1:0] row3,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*BIT_WIDTH-1:0] res_row0,
  output logic [4*BIT_WIDTH-1:0] res_row1,
  output logic [4*BIT_WIDTH-1:0] res_row2,
  output logic [4*BIT_WIDTH-1:0] res_row3
`ifdef BUBBLE_CNT_EN
  ,
  output logic [15:0]            bubble_cnt
`endif
);

  localparam int             DCW        = $clog2(DRAIN_CYC + 1);
  localparam logic [7:0]     K_CLAMP    = 8'(MAX_K);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  // The lane wiring below is fixed at four; reject anything else at elaboration.
  if (N != 4 || DRAIN_CYC < 2 * N || FRAC_WIDTH >= BIT_WIDTH) begin : g_bad_cfg
    $error("systolic_feed_ctrl: unsupported parameter set");
  end

  state_t                 state_q, state_d;
  logic [7:0]             k_len_q, k_len_d;
  logic [7:0]             k_cnt_q, k_cnt_d;
  logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                   capture;
  logic                   accept;
  logic                   lane_clr;
  logic [4*BIT_WIDTH-1:0] row_in [4];
  logic [4*BIT_WIDTH-1:0] res_row_q [4];
  logic [BIT_WIDTH-1:0]   west_lane [4];
  logic [BIT_WIDTH-1:0]   north_lane [4];
`ifdef BUBBLE_CNT_EN
  logic [15:0]            bubble_q, bubble_d;
`endif

  assign accept   = (state_q == FEED) && in_valid;
  assign lane_clr = ~rst_n;

  // Skew lines: lane gi sees gi+1 registers; bubbles and non-FEED cycles push zeros.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    skew_line #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(gi + 1)) u_west (
      .clk (clk),
      .clr (lane_clr),
      .d   (accept ? a_col[gi*BIT_WIDTH +: BIT_WIDTH] : '0),
      .q   (west_lane[gi])
    );
    skew_line #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(gi + 1)) u_north (
      .clk (clk),
      .clr (lane_clr),
      .d   (accept ? b_row[gi*BIT_WIDTH +: BIT_WIDTH] : '0),
      .q   (north_lane[gi])
    );
  end

  // Next-state and counter updates; all defaults hold the current value.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    k_cnt_d     = k_cnt_q;
    drain_cnt_d = drain_cnt_q;
    capture     = 1'b0;
`ifdef BUBBLE_CNT_EN
    bubble_d    = bubble_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d = (k_len > K_CLAMP) ? K_CLAMP : k_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        k_cnt_d     = '0;
        drain_cnt_d = '0;
`ifdef BUBBLE_CNT_EN
        bubble_d    = '0;
`endif
        state_d     = (k_len_q != 8'd0) ? FEED : DRAIN;
      end
      FEED: begin
        if (accept) begin
          if (k_cnt_q < k_len_q) k_cnt_d = k_cnt_q + 8'd1;
          if (k_cnt_q + 8'd1 == k_len_q) state_d = DRAIN;
        end
`ifdef BUBBLE_CNT_EN
        if (!in_valid && bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
`endif
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      drain_cnt_q <= '0;
`ifdef BUBBLE_CNT_EN
      bubble_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      k_cnt_q     <= k_cnt_d;
      drain_cnt_q <= drain_cnt_d;
`ifdef BUBBLE_CNT_EN
      bubble_q    <= bubble_d;
`endif
    end
  end

  assign row_in[0] = row0;
  assign row_in[1] = row1;
  assign row_in[2] = row2;
  assign row_in[3] = row3;

  // Result capture on the last drain cycle; held until the next job's capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) res_row_q[r] <= '0;
    end else if (capture) begin
      for (int r = 0; r < 4; r++) res_row_q[r] <= row_in[r];
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == FEED);
  assign res_valid = (state_q == HOLD);
  assign arr_rst_n = rst_n & (state_q != CLEAR);

  assign west_in0  = west_lane[0];
  assign west_in1  = west_lane[1];
  assign west_in2  = west_lane[2];
  assign west_in3  = west_lane[3];
  assign north_in0 = north_lane[0];
  assign north_in1 = north_lane[1];
  assign north_in2 = north_lane[2];
  assign north_in3 = north_lane[3];

  assign res_row0  = res_row_q[0];
  assign res_row1  = res_row_q[1];
  assign res_row2  = res_row_q[2];
  assign res_row3  = res_row_q[3];
`ifdef BUBBLE_CNT_EN
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: drives systolic_feed_ctrl against a behavioural 4x4
// systolic array and checks results against a plain matrix-product model.
// Honours BUBBLE_CNT_EN when the design is built with it.
module tb_systolic_feed_ctrl;

  localparam int BW        = 16;
  localparam int DRAIN_CYC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, in_valid, res_ready;
  logic [7:0]    k_len;
  logic [63:0]   a_col, b_row;
  logic          busy, in_ready, arr_rst_n, res_valid;
  logic [15:0]   west_in0, west_in1, west_in2, west_in3;
  logic [15:0]   north_in0, north_in1, north_in2, north_in3;
  logic [63:0]   row0, row1, row2, row3;
  logic [63:0]   res_row0, res_row1, res_row2, res_row3;
`ifdef BUBBLE_CNT_EN
  logic [15:0]   bubble_cnt;
`endif

  systolic_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .arr_rst_n(arr_rst_n),
    .west_in0(west_in0), .west_in1(west_in1), .west_in2(west_in2), .west_in3(west_in3),
    .north_in0(north_in0), .north_in1(north_in1), .north_in2(north_in2), .north_in3(north_in3),
    .row0(row0), .row1(row1), .row2(row2), .row3(row3),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row0(res_row0), .res_row1(res_row1), .res_row2(res_row2), .res_row3(res_row3)
`ifdef BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  // Q8.8 multiply as the array performs it: full product, shifted, low 16 bits kept.
  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  // ---------------- behavioural systolic_array_4x4 ----------------
  logic [15:0] west_v [4], north_v [4];
  logic [15:0] pe_w [4][4], pe_n [4][4], pe_acc [4][4];
  logic [15:0] w_src [4][4], n_src [4][4];
  logic [63:0] row_v [4];

  assign west_v[0] = west_in0;   assign west_v[1] = west_in1;
  assign west_v[2] = west_in2;   assign west_v[3] = west_in3;
  assign north_v[0] = north_in0; assign north_v[1] = north_in1;
  assign north_v[2] = north_in2; assign north_v[3] = north_in3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_src[i][0] = west_v[i];
      n_src[0][i] = north_v[i];
      for (int j = 1; j < 4; j++) begin
        w_src[i][j] = pe_w[i][j-1];
        n_src[j][i] = pe_n[j-1][i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      row_v[i] = '0;
      for (int j = 0; j < 4; j++) row_v[i][j*16 +: 16] = pe_acc[i][j];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (!arr_rst_n) begin
          pe_w[i][j]   <= '0;
          pe_n[i][j]   <= '0;
          pe_acc[i][j] <= '0;
        end else begin
          pe_w[i][j]   <= w_src[i][j];
          pe_n[i][j]   <= n_src[i][j];
          pe_acc[i][j] <= pe_acc[i][j] + qmul(w_src[i][j], n_src[i][j]);
        end
      end
    end
  end

  assign row0 = row_v[0];
  assign row1 = row_v[1];
  assign row2 = row_v[2];
  assign row3 = row_v[3];

  // ---------------- bench state ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int arr_low_cnt = 0;
  int job_lat, job_bub, job_rdy;
  logic [63:0] a_mem [256];
  logic [63:0] b_mem [256];
  logic [63:0] ref_row [4];
  logic [63:0] res_v [4];

  assign res_v[0] = res_row0; assign res_v[1] = res_row1;
  assign res_v[2] = res_row2; assign res_v[3] = res_row3;

  // Cycles where the array is held in reset by the controller alone.
  always @(posedge clk) if (rst_n && !arr_rst_n) arr_low_cnt <= arr_low_cnt + 1;

  // Reference: C[i][j] = sum over k of A[i][k]*B[k][j] in Q8.8.
  task automatic calc_ref(input int k);
    logic [15:0] acc;
    for (int i = 0; i < 4; i++) begin
      ref_row[i] = '0;
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int kk = 0; kk < k; kk++) acc = acc + qmul(a_mem[kk][i*16 +: 16], b_mem[kk][j*16 +: 16]);
        ref_row[i][j*16 +: 16] = acc;
      end
    end
  endtask

  task automatic fill_ramp(input int k);
    logic [15:0] v;
    for (int kk = 0; kk < k; kk++) begin
      v = 16'((kk + 1) * 256);
      a_mem[kk] = {v, v, v, v};
      b_mem[kk] = {4{16'h0100}};
    end
  endtask

  // Runs one job up to res_valid. mode 0: no bubbles, 1: every other cycle, 2: random.
  task automatic do_job(input int k, input int mode);
    int  idx;
    bit  drove, phase, want;
    idx = 0; drove = 0; phase = 1;
    job_lat = 0; job_bub = 0; job_rdy = 0;
    @(posedge clk); #1;
    start = 1'b1; k_len = 8'(k); in_valid = 1'b0;
    while (job_lat < 2000) begin
      @(posedge clk);
      job_lat++;
      if (drove) idx++;
      #1;
      start = 1'b0; drove = 0; in_valid = 1'b0;
      if (res_valid) break;
      if (in_ready) begin
        job_rdy++;
        if (idx < k) begin
          if (mode == 0) want = 1;
          else if (mode == 1) begin want = phase; phase = ~phase; end
          else want = 1'($urandom_range(0, 1));
          if (want) begin
            in_valid = 1'b1; a_col = a_mem[idx]; b_row = b_mem[idx]; drove = 1;
          end else begin
            a_col = {$urandom, $urandom}; b_row = {$urandom, $urandom}; job_bub++;
          end
        end
      end
    end
    if (res_valid !== 1'b1) begin
      vec_cnt++; err_cnt++;
      $display("FAIL job_timeout res_valid got %b exp 1 after %0d cycles", res_valid, job_lat);
    end
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vec_cnt++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL release got res_valid=%b busy=%b exp 0 0", res_valid, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({busy, in_ready, res_valid, arr_rst_n} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_ctrl got %b exp 0000", {busy, in_ready, res_valid, arr_rst_n});
    end
    vec_cnt++;
    if ({west_in0, west_in1, west_in2, west_in3, north_in0, north_in1, north_in2, north_in3} !== 128'd0) begin
      err_cnt++;
      $display("FAIL reset_lanes got %h exp 0",
               {west_in0, west_in1, west_in2, west_in3, north_in0, north_in1, north_in2, north_in3});
    end
    vec_cnt++;
    if ({res_row0, res_row1, res_row2, res_row3} !== 256'd0) begin
      err_cnt++;
      $display("FAIL reset_res got %h exp 0", {res_row0, res_row1, res_row2, res_row3});
    end
    rst_n = 1'b1;
    #1;
    vec_cnt++;
    if (arr_rst_n !== 1'b1) begin
      err_cnt++;
      $display("FAIL arr_rst_release got %b exp 1", arr_rst_n);
    end
  endtask

  task automatic test_basic();
    fill_ramp(4);
    do_job(4, 0);
    vec_cnt++;
    if (job_lat != 14) begin err_cnt++; $display("FAIL basic_latency got %0d exp 14", job_lat); end
    vec_cnt++;
    if (job_rdy != 4) begin err_cnt++; $display("FAIL basic_ready_cycles got %0d exp 4", job_rdy); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (res_v[i] !== {4{16'h0A00}}) begin
        err_cnt++;
        $display("FAIL basic_row%0d got %h exp %h", i, res_v[i], {4{16'h0A00}});
      end
    end
    take_result();
  endtask

  task automatic test_bubbles();
    fill_ramp(4);
    do_job(4, 1);
    vec_cnt++;
    if (job_lat != 17) begin err_cnt++; $display("FAIL bubble_latency got %0d exp 17", job_lat); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (res_v[i] !== {4{16'h0A00}}) begin
        err_cnt++;
        $display("FAIL bubble_row%0d got %h exp %h", i, res_v[i], {4{16'h0A00}});
      end
    end
`ifdef BUBBLE_CNT_EN
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (bubble_cnt !== 16'd3) begin err_cnt++; $display("FAIL bubble_cnt got %0d exp 3", bubble_cnt); end
`endif
    take_result();
  endtask

  task automatic test_back_to_back();
    int low0;
    fill_ramp(4);
    low0 = arr_low_cnt;
    do_job(4, 0);
    vec_cnt++;
    if (arr_low_cnt - low0 != 1) begin
      err_cnt++; $display("FAIL b2b_clear1 got %0d exp 1", arr_low_cnt - low0);
    end
    take_result();
    for (int kk = 0; kk < 4; kk++) b_mem[kk] = '0;
    low0 = arr_low_cnt;
    do_job(4, 0);
    vec_cnt++;
    if (arr_low_cnt - low0 != 1) begin
      err_cnt++; $display("FAIL b2b_clear2 got %0d exp 1", arr_low_cnt - low0);
    end
    vec_cnt++;
    if ({res_row0, res_row1, res_row2, res_row3} !== 256'd0) begin
      err_cnt++; $display("FAIL b2b_zero_result got %h exp 0", {res_row0, res_row1, res_row2, res_row3});
    end
    take_result();
  endtask

  task automatic test_zero_k();
    fill_ramp(4);
    do_job(4, 0);
    take_result();
    do_job(0, 0);
    vec_cnt++;
    if (job_rdy != 0) begin err_cnt++; $display("FAIL zerok_ready got %0d exp 0", job_rdy); end
    vec_cnt++;
    if (job_lat != 2 + DRAIN_CYC) begin
      err_cnt++; $display("FAIL zerok_latency got %0d exp %0d", job_lat, 2 + DRAIN_CYC);
    end
    vec_cnt++;
    if ({res_row0, res_row1, res_row2, res_row3} !== 256'd0) begin
      err_cnt++; $display("FAIL zerok_result got %h exp 0", {res_row0, res_row1, res_row2, res_row3});
    end
    take_result();
  endtask

  task automatic test_hold();
    fill_ramp(4);
    do_job(4, 0);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2); k_len = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      vec_cnt++;
      if ({res_row0, res_row1, res_row2, res_row3} !== {16{16'h0A00}} || busy !== 1'b1 || res_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL hold_cycle%0d got busy=%b valid=%b rows=%h exp 1 1 all 0a00", c, busy, res_valid,
                 {res_row0, res_row1, res_row2, res_row3});
      end
    end
    take_result();
    @(posedge clk); #1;
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL hold_start_ignored busy got %b exp 0", busy); end
  endtask

  task automatic test_mid_reset();
    fill_ramp(4);
    @(posedge clk); #1;
    start = 1'b1; k_len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL midrst_first_ready got %b exp 1", in_ready); end
    for (int kk = 0; kk < 2; kk++) begin
      in_valid = 1'b1; a_col = a_mem[kk]; b_row = b_mem[kk];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (arr_rst_n !== 1'b0) begin err_cnt++; $display("FAIL midrst_arr_rst got %b exp 0", arr_rst_n); end
    @(posedge clk); #1;
    vec_cnt++;
    if ({busy, in_ready, res_valid} !== 3'b000) begin
      err_cnt++; $display("FAIL midrst_ctrl got %b exp 000", {busy, in_ready, res_valid});
    end
    vec_cnt++;
    if ({west_in0, west_in1, west_in2, west_in3, north_in0, north_in1, north_in2, north_in3,
         res_row0, res_row1, res_row2, res_row3} !== 384'd0) begin
      err_cnt++; $display("FAIL midrst_outputs got nonzero exp 0 (west0=%h res0=%h)", west_in0, res_row0);
    end
    rst_n = 1'b1;
    for (int kk = 0; kk < 6; kk++) begin
      a_mem[kk] = {$urandom, $urandom};
      b_mem[kk] = {$urandom, $urandom};
    end
    calc_ref(6);
    do_job(6, 0);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (res_v[i] !== ref_row[i]) begin
        err_cnt++; $display("FAIL midrst_fresh_row%0d got %h exp %h", i, res_v[i], ref_row[i]);
      end
    end
    take_result();
  endtask

  task automatic test_random();
    int k, mode;
    for (int r = 0; r < 5; r++) begin
      k    = (r == 0) ? 255 : $urandom_range(1, 20);
      mode = (r == 0) ? 0 : 2;
      for (int kk = 0; kk < k; kk++) begin
        a_mem[kk] = {$urandom, $urandom};
        b_mem[kk] = {$urandom, $urandom};
      end
      calc_ref(k);
      do_job(k, mode);
      vec_cnt++;
      if (job_lat != 2 + k + job_bub + DRAIN_CYC) begin
        err_cnt++;
        $display("FAIL rand%0d_latency got %0d exp %0d", r, job_lat, 2 + k + job_bub + DRAIN_CYC);
      end
      for (int i = 0; i < 4; i++) begin
        vec_cnt++;
        if (res_v[i] !== ref_row[i]) begin
          err_cnt++; $display("FAIL rand%0d_row%0d got %h exp %h", r, i, res_v[i], ref_row[i]);
        end
      end
`ifdef BUBBLE_CNT_EN
      vec_cnt++;
      if (bubble_cnt !== 16'(job_bub)) begin
        err_cnt++; $display("FAIL rand%0d_bubble_cnt got %0d exp %0d", r, bubble_cnt, job_bub);
      end
`endif
      take_result();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
    res_ready = 1'b0; a_col = '0; b_row = '0;
    test_reset();
    test_basic();
    test_bubbles();
    test_back_to_back();
    test_zero_k();
    test_hold();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
